// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: digit/segment widths and the active-low hex glyph table.
// Used by both the multiplexed display driver and the scan-bus capture block.
package seven_seg_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = DIGITS * NIB_W;
  localparam int unsigned GLYPHS = 16;
  localparam int unsigned SEL_W  = $clog2(DIGITS);

  typedef logic [NIB_W-1:0] nibble_t;

  // Active-low segment patterns, seg[0]=a .. seg[6]=g, for 0-9,A,b,C,d,E,F
  localparam logic [SEG_W-1:0] GLYPH_LUT [GLYPHS] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational reverse lookup of an active-low segment pattern to its hex nibble.
// hit_c is low for any pattern that is not one of the 16 hex glyphs; nibble_c is then 0.
module seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             hit_c,
  output logic [NIB_W-1:0] nibble_c
);

  always_comb begin
    hit_c    = 1'b0;
    nibble_c = '0;
    for (int i = 0; i < int'(GLYPHS); i++) begin
      if (seg == GLYPH_LUT[i]) begin
        hit_c    = 1'b1;
        nibble_c = NIB_W'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Capture side of a multiplexed 4-digit seven-segment scan bus: settles, decodes and assembles
// digits into a 16-bit word with glyph-error and stale-scan flags.
// Optional CAPTURE_CHANGE_ONLY_EN: strobe value_valid only when the word or error flag changes.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [DIGITS-1:0]   AN,
  input  logic [SEG_W-1:0]    seg,
  output logic [WORD_W-1:0]   value,
  output logic                value_valid,
  output logic                frame_err,
  output logic                stale
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  logic [DIGITS-1:0] an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
  logic [SEG_W-1:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DIGITS-1:0] seen_q, seen_d, err_q, err_d;
  logic [WORD_W-1:0] slots_q, slots_d, value_q, value_d;
  logic              valid_q, valid_d, ferr_q, ferr_d, stale_q, stale_d;
`ifdef CAPTURE_CHANGE_ONLY_EN
  logic              first_q, first_d;
`endif

  logic [CNT_W-1:0]  low_cnt_c;
  logic [SEL_W-1:0]  sel_idx_c;
  logic              sel_legal_c;
  logic              capture_c;
  logic [DIGITS-1:0] cap_bit_c;
  logic              hit_c;
  logic [NIB_W-1:0]  nibble_c;

  seg_glyph_decode u_decode (
    .seg      (seg_s2_q),
    .hit_c    (hit_c),
    .nibble_c (nibble_c)
  );

  // Digit select is legal only with exactly one anode low
  always_comb begin
    low_cnt_c = '0;
    sel_idx_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!an_s2_q[i]) begin
        low_cnt_c = low_cnt_c + CNT_W'(1);
        sel_idx_c = SEL_W'(i);
      end
    end
    sel_legal_c = (low_cnt_c == CNT_W'(1));
  end

  always_comb begin
    an_s1_d    = AN;
    an_s2_d    = an_s1_q;
    seg_s1_d   = seg;
    seg_s2_d   = seg_s1_q;
    an_prev_d  = an_s2_q;
    seg_prev_d = seg_s2_q;
    seen_d     = seen_q;
    err_d      = err_q;
    slots_d    = slots_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    ferr_d     = ferr_q;
    stale_d    = stale_q;
    cap_bit_c  = '0;
`ifdef CAPTURE_CHANGE_ONLY_EN
    first_d    = first_q;
`endif

    if (sel_legal_c && (an_s2_q == an_prev_q) && (seg_s2_q == seg_prev_q)) begin
      settle_d = (settle_q == SET_MAX) ? settle_q : settle_q + SET_W'(1);
    end else begin
      settle_d = '0;
    end
    // Fires only on the transition into saturation: once per dwell
    capture_c = (settle_d == SET_MAX) && (settle_q != SET_MAX);

    if (capture_c) begin
      cap_bit_c[sel_idx_c]                  = 1'b1;
      slots_d[sel_idx_c*NIB_W +: NIB_W]     = nibble_c;
      err_d[sel_idx_c]                      = ~hit_c;
      seen_d[sel_idx_c]                     = 1'b1;
    end

    if (&seen_q) begin
      value_d = slots_q;
      ferr_d  = |err_q;
      seen_d  = cap_bit_c;
`ifdef CAPTURE_CHANGE_ONLY_EN
      valid_d = first_q || (slots_q != value_q) || ((|err_q) != ferr_q);
      first_d = 1'b0;
`else
      valid_d = 1'b1;
`endif
    end

    if (capture_c) begin
      tmo_d   = '0;
      stale_d = 1'b0;
    end else begin
      tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
    end
    // Scan stopped: drop any partial frame
    if (tmo_d == TMO_MAX) begin
      stale_d = 1'b1;
      seen_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      an_s1_q    <= '1;
      an_s2_q    <= '1;
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      an_prev_q  <= '1;
      seg_prev_q <= '1;
      settle_q   <= '0;
      tmo_q      <= '0;
      seen_q     <= '0;
      err_q      <= '0;
      slots_q    <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      stale_q    <= 1'b0;
`ifdef CAPTURE_CHANGE_ONLY_EN
      first_q    <= 1'b1;
`endif
    end else begin
      an_s1_q    <= an_s1_d;
      an_s2_q    <= an_s2_d;
      seg_s1_q   <= seg_s1_d;
      seg_s2_q   <= seg_s2_d;
      an_prev_q  <= an_prev_d;
      seg_prev_q <= seg_prev_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      seen_q     <= seen_d;
      err_q      <= err_d;
      slots_q    <= slots_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      stale_q    <= stale_d;
`ifdef CAPTURE_CHANGE_ONLY_EN
      first_q    <= first_d;
`endif
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign frame_err   = ferr_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: emulated scan frames, glyph errors, settle boundary,
// illegal selects, stale timeout, mid-frame reset and repeated frames.
module tb_seven_seg_capture;

  localparam int unsigned TMO   = 100;
  localparam int          DWELL = 24;
  localparam logic [6:0] G [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  AN = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] value;
  logic        value_valid;
  logic        frame_err;
  logic        stale;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  int base     = 0;
  int exp_rep  = 0;

  seven_seg_capture #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .AN          (AN),
    .seg         (seg),
    .value       (value),
    .value_valid (value_valid),
    .frame_err   (frame_err),
    .stale       (stale)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (value_valid) strobes++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    AN  = ~(4'b0001 << d);
    seg = s;
    hold(n);
  endtask

  task automatic blank(input int n);
    AN  = 4'hF;
    seg = 7'h7F;
    hold(n);
  endtask

  task automatic frame(input logic [15:0] w);
    for (int i = 0; i < 4; i++) show(i, G[w[i*4 +: 4]], DWELL);
    blank(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hold(3);
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(value_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    RST_N = 1'b1;
    blank(4);

    // Plain frame
    base = strobes;
    frame(16'hF3C0);
    check("t1_strobes", 32'(strobes), 32'(base + 1));
    check("t1_value", 32'(value), 32'hF3C0);
    check("t1_ferr", 32'(frame_err), 32'h0);

    // Blank glyph on digit 2
    base = strobes;
    show(0, G[0], DWELL);
    show(1, G[12], DWELL);
    show(2, 7'h7F, DWELL);
    show(3, G[15], DWELL);
    blank(6);
    check("t2_strobes", 32'(strobes), 32'(base + 1));
    check("t2_value", 32'(value), 32'hF0C0);
    check("t2_ferr", 32'(frame_err), 32'h1);

    // Settle boundary: 16 synced cycles never capture, 17 do
    base = strobes;
    show(1, G[10], DWELL);
    show(2, G[2], DWELL);
    show(3, G[1], DWELL);
    show(0, G[5], 16);
    show(0, G[6], 16);
    show(0, G[9], 16);
    blank(4);
    check("t3_no_cap", 32'(strobes), 32'(base));
    show(0, G[9], 17);
    blank(6);
    check("t3_strobes", 32'(strobes), 32'(base + 1));
    check("t3_value", 32'(value), 32'h12A9);
    check("t3_ferr", 32'(frame_err), 32'h0);

    // Two anodes low is blanking
    base = strobes;
    show(0, G[4], DWELL);
    show(1, G[5], DWELL);
    show(2, G[6], DWELL);
    AN  = 4'b0011;
    seg = G[8];
    hold(60);
    check("t4_multi_low", 32'(strobes), 32'(base));
    show(3, G[7], DWELL);
    blank(6);
    check("t4_strobes", 32'(strobes), 32'(base + 1));
    check("t4_value", 32'(value), 32'h7654);

    // Stale after scan stops, partial frame dropped
    base = strobes;
    show(0, G[1], DWELL);
    show(1, G[2], DWELL);
    blank(80);
    check("t5_not_stale", 32'(stale), 32'h0);
    blank(40);
    check("t5_stale", 32'(stale), 32'h1);
    check("t5_value_held", 32'(value), 32'h7654);
    show(2, G[3], DWELL);
    check("t5_stale_clr", 32'(stale), 32'h0);
    show(3, G[4], DWELL);
    blank(6);
    check("t5_seen_clr", 32'(strobes), 32'(base));
    show(0, G[5], DWELL);
    show(1, G[6], DWELL);
    blank(6);
    check("t5_strobes", 32'(strobes), 32'(base + 1));
    check("t5_value", 32'(value), 32'h4365);

    // Reset mid-frame
    show(0, G[1], DWELL);
    show(1, G[2], DWELL);
    show(2, G[3], DWELL);
    RST_N = 1'b0;
    #1;
    check("t6_rst_value", 32'(value), 32'h0);
    check("t6_rst_valid", 32'(value_valid), 32'h0);
    check("t6_rst_ferr", 32'(frame_err), 32'h0);
    check("t6_rst_stale", 32'(stale), 32'h0);
    hold(3);
    RST_N = 1'b1;
    base = strobes;
    show(3, G[11], DWELL);
    blank(6);
    check("t6_partial", 32'(strobes), 32'(base));
    show(0, G[8], DWELL);
    show(1, G[9], DWELL);
    show(2, G[10], DWELL);
    blank(6);
    check("t6_strobes", 32'(strobes), 32'(base + 1));
    check("t6_value", 32'(value), 32'hBA98);

    // Repeated identical frames
`ifdef CAPTURE_CHANGE_ONLY_EN
    exp_rep = 0;
`else
    exp_rep = 2;
`endif
    base = strobes;
    frame(16'hBA98);
    frame(16'hBA98);
    check("t7_repeat", 32'(strobes), 32'(base + exp_rep));
    frame(16'h0F5A);
    check("t7_change", 32'(strobes), 32'(base + exp_rep + 1));
    check("t7_value", 32'(value), 32'h0F5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
